// File: rtl/periph_arbiter.sv
// Two-master round-robin arbiter onto a single-beat peripheral bus (IDLE -> ACCESS -> ACK).
// Define PERIPH_ARB_LOCK_EN to let a locking master keep the bus for up to LOCK_MAX grants.
module periph_arbiter #(
    parameter int LOCK_MAX = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              rd,
    output logic              wr,
    output logic [31:0]       addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t state;
    logic   gsel;
    logic   ptr;
    logic   win;
    logic   sel_wr;

    assign sel_wr = gsel ? m1_wr : m0_wr;

`ifdef PERIPH_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] lock_cnt;
    logic             lock_force;

    // The previously served master keeps the bus while its lock run is live and it still requests.
    assign lock_force = (lock_cnt != '0) && (lock_cnt < LOCK_MAX_C) &&
                        (gsel ? m1_req : m0_req);
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
`endif

    always_comb begin
        win = ptr;
        if (m0_req && !m1_req)
            win = 1'b0;
        else if (m1_req && !m0_req)
            win = 1'b1;
`ifdef PERIPH_ARB_LOCK_EN
        if (lock_force)
            win = gsel;
`endif
    end

    // Bus is driven only during ACCESS; state resets asynchronously, so strobes drop with reset.
    always_comb begin
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (state == ACCESS) begin
            wr    = sel_wr;
            rd    = !sel_wr;
            addr  = gsel ? m1_addr  : m0_addr;
            wdata = gsel ? m1_wdata : m0_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gsel     <= 1'b0;
            ptr      <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
`ifdef PERIPH_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gsel  <= win;
                        ptr   <= !win;
                        state <= ACCESS;
`ifdef PERIPH_ARB_LOCK_EN
                        if (win != gsel)
                            lock_cnt <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (!sel_wr) begin
                        if (gsel)
                            m1_rdata <= rdata;
                        else
                            m0_rdata <= rdata;
                    end
                    m0_ack <= !gsel;
                    m1_ack <= gsel;
                    state  <= ACK;
                end
                ACK: begin
                    state <= IDLE;
`ifdef PERIPH_ARB_LOCK_EN
                    if (gsel ? m1_lock : m0_lock) begin
                        if (lock_cnt != LOCK_MAX_C)
                            lock_cnt <= lock_cnt + 1'b1;
                    end else begin
                        lock_cnt <= '0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_arbiter.sv
// Directed bench for periph_arbiter: single-transaction vector table plus stream, lock and reset-abort sequences.
module tb_periph_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata, addr, wdata, rdata;
    logic        m0_ack, m1_ack, rd, wr;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    periph_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    typedef struct {
        logic        m0_req;
        logic        m0_wr;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_wr;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic [31:0] bus_rdata;
        logic        exp_g;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_m0_rdata;
        logic [31:0] exp_m1_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
        rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        m0_req = v.m0_req; m0_wr = v.m0_wr; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
        m1_req = v.m1_req; m1_wr = v.m1_wr; m1_addr = v.m1_addr; m1_wdata = v.m1_wdata;
        rdata  = v.bus_rdata;
        @(posedge clk); #1;
        chk($sformatf("v%0d wr", i), {31'd0, wr}, {31'd0, v.exp_wr});
        chk($sformatf("v%0d rd", i), {31'd0, rd}, {31'd0, !v.exp_wr});
        chk($sformatf("v%0d addr", i), addr, v.exp_addr);
        chk($sformatf("v%0d wdata", i), wdata, v.exp_wdata);
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1;
        chk($sformatf("v%0d m0_ack", i), {31'd0, m0_ack}, {31'd0, !v.exp_g});
        chk($sformatf("v%0d m1_ack", i), {31'd0, m1_ack}, {31'd0, v.exp_g});
        chk($sformatf("v%0d m0_rdata", i), m0_rdata, v.exp_m0_rdata);
        chk($sformatf("v%0d m1_rdata", i), m1_rdata, v.exp_m1_rdata);
        @(posedge clk); #1;
        chk($sformatf("v%0d idle bus", i), {28'd0, rd, wr, m0_ack, m1_ack}, 32'd0);
    endtask

    // pat bit n is the master expected for the n-th grant; grants must be 3 cycles apart.
    task automatic run_stream(input string name, input logic lock0, input logic [9:0] pat);
        int n = 0;
        int last = 0;
        int bad = 0;
        idle_inputs();
        do_reset();
        m0_req = 1; m0_wr = 1; m0_addr = 32'h4000_0100; m0_wdata = 32'h1; m0_lock = lock0;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h4000_0200; rdata = 32'h55;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(posedge clk); #1;
            if ((rd && wr) || (m0_ack && m1_ack)) bad++;
            if (rd || wr) begin
                chk($sformatf("%s grant%0d master", name, n),
                    {31'd0, addr == 32'h4000_0200}, {31'd0, pat[n]});
                if (n > 0) chk($sformatf("%s grant%0d gap", name, n), c - last, 3);
                last = c;
                n++;
            end
        end
        chk($sformatf("%s grant count", name), n, 10);
        chk($sformatf("%s exclusivity", name), bad, 0);
        idle_inputs();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h4000_000C, 32'h0000_00A5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b1, 32'h4000_000C, 32'h0000_00A5, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4000_0010, 32'hDEAD_0001, 32'h0000_003C,
                    1'b1, 1'b0, 32'h4000_0010, 32'hDEAD_0001, 32'h0, 32'h0000_003C};
        vecs[2] = '{1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678,
                    1'b0, 1'b0, 32'h4000_0000, 32'h0, 32'h1234_5678, 32'h0000_003C};
        vecs[3] = '{1'b1, 1'b1, 32'h4000_0020, 32'h1, 1'b1, 1'b0, 32'h4000_0024, 32'h2, 32'hCAFE_F00D,
                    1'b1, 1'b0, 32'h4000_0024, 32'h2, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 32'h4000_0030, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h4000_0034, 32'h3, 32'hAAAA_5555,
                    1'b0, 1'b1, 32'h4000_0030, 32'hFFFF_FFFF, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4000_003C, 32'h8000_0000, 32'h9999_9999,
                    1'b1, 1'b1, 32'h4000_003C, 32'h8000_0000, 32'h1234_5678, 32'hCAFE_F00D};

        idle_inputs();
        reset = 1'b0;
        #3;
        chk("reset bus", {28'd0, rd, wr, m0_ack, m1_ack}, 32'd0);
        chk("reset addr", addr, 32'd0);
        chk("reset wdata", wdata, 32'd0);
        chk("reset m0_rdata", m0_rdata, 32'd0);
        chk("reset m1_rdata", m1_rdata, 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an m0 write: strobe drops at once, no ack, pointer back to m0.
        idle_inputs();
        m0_req = 1; m0_wr = 1; m0_addr = 32'h4000_0040; m0_wdata = 32'h77;
        @(posedge clk); #1;
        chk("abort pre wr", {31'd0, wr}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort wr drop", {30'd0, rd, wr}, 32'd0);
        chk("abort addr drop", addr, 32'd0);
        chk("abort m1_rdata cleared", m1_rdata, 32'd0);
        @(posedge clk); #1;
        chk("abort no ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        #2 reset = 1'b1;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h4000_0044;
        @(posedge clk); #1;
        chk("after abort winner addr", addr, 32'h4000_0040);
        chk("after abort wr", {31'd0, wr}, 32'd1);
        idle_inputs();
        @(posedge clk); #1;
        chk("after abort m0_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
        @(posedge clk);

        run_stream("rr", 1'b0, 10'b1010101010);
`ifdef PERIPH_ARB_LOCK_EN
        run_stream("lock", 1'b1, 10'b1000010000);
`else
        run_stream("lock", 1'b1, 10'b1010101010);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
